tmr_vote_monitor: RTL and testbench

TMR_VOTE_MONITOR -- requirements
Module: tmr_vote_monitor

---
 rtl/tmr_vote_monitor.sv | 192 +++++++++++++++++++
 tb/tb_tmr_vote_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tmr_vote_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tmr_vote_monitor
// Description : 2-of-3 majority voter for a triplicated 1-bit signal, with
//               per-channel disagreement tracking (OK / SUSPECT / FAULT) and
//               an optional saturating count of mismatching samples.
// Parameters  : FAULT_THRESH - consecutive valid disagreements before a
//                              channel is declared faulty (1..15)
//               CNT_W        - width of mismatch_cnt
// Ports       : clk, rst_n (async assert, active low)
//               in_valid, a, b, c  - sample strobe and channel 0/1/2 inputs
//               fault_clr          - synchronous clear of fault tracking
//               m, m_valid         - registered majority and its update strobe
//               mismatch, odd_ch   - disagreement pulse and one-hot odd channel
//               fault_ch           - sticky per-channel fault flags
//               mismatch_cnt       - saturating mismatch count
// Macro       : TMR_MISMATCH_CNT_EN - when defined, mismatch_cnt is a real
//               saturating counter; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_vote_monitor #(
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             fault_clr,
    output logic             m,
    output logic             m_valid,
    output logic             mismatch,
    output logic [2:0]       odd_ch,
    output logic [2:0]       fault_ch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [3:0] C_THRESH = 4'(FAULT_THRESH);

    // ------------------------------------------------------------------
    // Combinational vote of the current sample
    // ------------------------------------------------------------------
    logic       maj_w;
    logic [2:0] odd_w;
    logic       mis_w;

    always_comb begin
        maj_w    = (a & b) | (a & c) | (b & c);
        // A channel is odd when the other two agree with each other but not with it.
        odd_w[0] = (b == c) && (a != b);
        odd_w[1] = (a == c) && (b != a);
        odd_w[2] = (a == b) && (c != a);
        mis_w    = |odd_w;
    end

    // ------------------------------------------------------------------
    // Registered voter outputs
    // ------------------------------------------------------------------
    logic       m_q, m_d;
    logic       m_valid_q, m_valid_d;
    logic       mismatch_q, mismatch_d;
    logic [2:0] odd_ch_q, odd_ch_d;

    always_comb begin
        m_d        = m_q;
        m_valid_d  = 1'b0;
        mismatch_d = 1'b0;
        odd_ch_d   = 3'b000;
        if (in_valid) begin
            m_d        = maj_w;
            m_valid_d  = 1'b1;
            mismatch_d = mis_w;
            odd_ch_d   = odd_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q        <= 1'b0;
            m_valid_q  <= 1'b0;
            mismatch_q <= 1'b0;
            odd_ch_q   <= 3'b000;
        end else begin
            m_q        <= m_d;
            m_valid_q  <= m_valid_d;
            mismatch_q <= mismatch_d;
            odd_ch_q   <= odd_ch_d;
        end
    end

    assign m        = m_q;
    assign m_valid  = m_valid_q;
    assign mismatch = mismatch_q;
    assign odd_ch   = odd_ch_q;

    // ------------------------------------------------------------------
    // Per-channel health tracking
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_ch
        state_t     state_q, state_d;
        logic [3:0] dcnt_q, dcnt_d;

        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            // Clear takes priority over any sample arriving in the same cycle.
            if (fault_clr) begin
                state_d = ST_OK;
                dcnt_d  = 4'd0;
            end else if (in_valid) begin
                case (state_q)
                    ST_OK: begin
                        if (odd_w[i]) begin
                            dcnt_d  = 4'd1;
                            // A threshold of 1 faults on the very first disagreement.
                            state_d = (C_THRESH <= 4'd1) ? ST_FAULT : ST_SUSPECT;
                        end
                    end
                    ST_SUSPECT: begin
                        if (odd_w[i]) begin
                            dcnt_d = dcnt_q + 4'd1;
                            if ((dcnt_q + 4'd1) >= C_THRESH) begin
                                state_d = ST_FAULT;
                            end
                        end else begin
                            state_d = ST_OK;
                            dcnt_d  = 4'd0;
                        end
                    end
                    ST_FAULT: begin
                        // Sticky; the counter only climbs until it reaches the threshold.
                        if (odd_w[i] && (dcnt_q < C_THRESH)) begin
                            dcnt_d = dcnt_q + 4'd1;
                        end
                    end
                    default: begin
                        state_d = ST_OK;
                        dcnt_d  = 4'd0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_OK;
                dcnt_q  <= 4'd0;
            end else begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
            end
        end

        assign fault_ch[i] = (state_q == ST_FAULT);
    end

    // ------------------------------------------------------------------
    // Mismatch counter (unaffected by fault_clr)
    // ------------------------------------------------------------------
`ifdef TMR_MISMATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && mis_w && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mismatch_cnt = cnt_q;
`else
    assign mismatch_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmr_vote_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tmr_vote_monitor
// Description : Directed self-checking bench for tmr_vote_monitor. Instance
//               d0 uses the default parameters; d1 uses FAULT_THRESH=1 and
//               CNT_W=2 to exercise the threshold and saturation boundaries.
//               Expected counter values follow TMR_MISMATCH_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr_vote_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0;
    logic fault_clr = 1'b0;

    logic       m0, mv0, mis0;
    logic [2:0] odd0, flt0;
    logic [7:0] cnt0;
    logic       m1, mv1, mis1;
    logic [2:0] odd1, flt1;
    logic [1:0] cnt1;

    int checks = 0;
    int errors = 0;
    int mm     = 0;   // mismatching valid samples since the last reset

    always #5 clk = ~clk;

    tmr_vote_monitor #(.FAULT_THRESH(4), .CNT_W(8)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .fault_clr(fault_clr), .m(m0), .m_valid(mv0), .mismatch(mis0),
        .odd_ch(odd0), .fault_ch(flt0), .mismatch_cnt(cnt0)
    );

    tmr_vote_monitor #(.FAULT_THRESH(1), .CNT_W(2)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .fault_clr(fault_clr), .m(m1), .m_valid(mv1), .mismatch(mis1),
        .odd_ch(odd1), .fault_ch(flt1), .mismatch_cnt(cnt1)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp0(input string tag, input logic em, input logic emv,
                        input logic emis, input logic [2:0] eodd, input logic [2:0] eflt);
        chk({tag, ".m"},        {7'd0, m0},   {7'd0, em});
        chk({tag, ".m_valid"},  {7'd0, mv0},  {7'd0, emv});
        chk({tag, ".mismatch"}, {7'd0, mis0}, {7'd0, emis});
        chk({tag, ".odd_ch"},   {5'd0, odd0}, {5'd0, eodd});
        chk({tag, ".fault_ch"}, {5'd0, flt0}, {5'd0, eflt});
    endtask

    task automatic chk_cnt(input string tag);
        logic [7:0] e0, e1;
`ifdef TMR_MISMATCH_CNT_EN
        e0 = (mm > 255) ? 8'd255 : 8'(mm);
        e1 = (mm > 3)   ? 8'd3   : 8'(mm);
`else
        e0 = 8'd0;
        e1 = 8'd0;
`endif
        chk({tag, ".cnt0"}, cnt0, e0);
        chk({tag, ".cnt1"}, {6'd0, cnt1}, e1);
    endtask

    // One clock: inputs applied at the falling edge, outputs sampled 1ns after the rising edge.
    task automatic step(input logic v, input logic [2:0] abc, input logic clr);
        @(negedge clk);
        in_valid  = v;
        a         = abc[2];
        b         = abc[1];
        c         = abc[0];
        fault_clr = clr;
        if (v && (abc != 3'b000) && (abc != 3'b111)) mm++;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        fault_clr = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        exp0("rst", 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("rst.d1_fault", {5'd0, flt1}, 8'd0);
        chk_cnt("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- basic voting ----------------
        step(1'b1, 3'b110, 1'b0);
        exp0("s110", 1'b1, 1'b1, 1'b1, 3'b100, 3'b000);
        chk("s110.d1_fault", {5'd0, flt1}, 8'h04);
        step(1'b1, 3'b001, 1'b0);
        exp0("s001", 1'b0, 1'b1, 1'b1, 3'b100, 3'b000);
        step(1'b1, 3'b111, 1'b0);
        exp0("s111", 1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b0, 3'b000, 1'b0);
        exp0("idle", 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b0, 3'b000, 1'b1);
        chk("clr.d1_fault", {5'd0, flt1}, 8'd0);
        chk_cnt("basic");

        // ---------------- c wrong four times ----------------
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b110, 1'b0);
            chk("c4.fault", {5'd0, flt0}, (i == 3) ? 8'h04 : 8'h00);
        end
        chk_cnt("c4");
        step(1'b0, 3'b000, 1'b1);
        chk("c4clr.fault", {5'd0, flt0}, 8'h00);

        // 3 wrong, 1 correct, 3 wrong: never reaches the threshold
        for (int i = 0; i < 3; i++) step(1'b1, 3'b110, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b110, 1'b0);
        chk("c3_1_3.fault", {5'd0, flt0}, 8'h00);
        chk_cnt("c3_1_3");
        step(1'b0, 3'b000, 1'b1);

        // ---------------- b wrong with idle gaps ----------------
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b101, 1'b0);
            chk("bgap.fault", {5'd0, flt0}, (i == 3) ? 8'h02 : 8'h00);
            step(1'b0, 3'b000, 1'b0);
        end
        chk_cnt("bgap");
        step(1'b0, 3'b000, 1'b1);

        // ---------------- clear colliding with a sample ----------------
        for (int i = 0; i < 4; i++) step(1'b1, 3'b011, 1'b0);
        chk("a4.fault", {5'd0, flt0}, 8'h01);
        step(1'b1, 3'b011, 1'b1);
        exp0("clrvalid", 1'b1, 1'b1, 1'b1, 3'b001, 3'b000);
        chk_cnt("clrvalid");
        step(1'b1, 3'b011, 1'b0);
        chk("postclr.fault", {5'd0, flt0}, 8'h00);

        // ---------------- reset aborts SUSPECT progress ----------------
        step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b011, 1'b0);
        chk("pre_rst.fault", {5'd0, flt0}, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        mm    = 0;
        #1;
        exp0("midrst", 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("midrst.d1_fault", {5'd0, flt1}, 8'd0);
        chk_cnt("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b011, 1'b0);
            chk_cnt("post_rst");
        end
        chk("post_rst3.fault", {5'd0, flt0}, 8'h00);
        step(1'b1, 3'b011, 1'b0);
        chk("post_rst4.fault", {5'd0, flt0}, 8'h01);
        chk_cnt("post_rst4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
